// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the flow-controlled pipeline stage register.
//   occ_state_e  : stage occupancy state; the encoding equals the number of
//                  stored entries and is driven straight onto `occupancy`.
//   src_sel_e    : where a storage position gets its entry from after the
//                  accept/emit update (nothing, the input, main or skid).
//   KILL_CNT_W   : width of the flush-kill performance counter.
//   kill_cnt_add : saturating add used by the kill counter.
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IN   = 2'd1,
        SRC_MAIN = 2'd2,
        SRC_SKID = 2'd3
    } src_sel_e;

    localparam int KILL_CNT_W = 16;

    // Add 0..2 killed beats to the counter, sticking at all-ones.
    function automatic logic [KILL_CNT_W-1:0] kill_cnt_add(
        input logic [KILL_CNT_W-1:0] base,
        input logic [1:0]            inc
    );
        logic [KILL_CNT_W:0] sum;
        sum = {1'b0, base} + {{(KILL_CNT_W-1){1'b0}}, inc};
        if (sum[KILL_CNT_W]) begin
            return {KILL_CNT_W{1'b1}};
        end else begin
            return sum[KILL_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage entry of the stage register: {valid, noflush, ctrl, data, keep}.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   load                    : capture load_* fields this edge
//   kill                    : entry is killed by a flush this edge; combined
//                             with load the keep field is still captured
//   clear                   : entry leaves the slot (emitted or moved on)
//   load_noflush/ctrl/data/keep : fields to capture
//   valid/noflush/ctrl/data/keep : stored entry
// Whenever the slot becomes invalid its ctrl field is zeroed (and its data
// field too when ZERO_DATA=1) so the head can drive outputs directly; keep is
// never zeroed outside reset.
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 96,
    parameter int KEEP_W    = 32,
    parameter bit ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              kill,
    input  logic              clear,
    input  logic              load_noflush,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    output logic              valid,
    output logic              noflush,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep
);

    logic              valid_r;
    logic              noflush_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;
    logic [KEEP_W-1:0] keep_r;

    // Entry register: load, load-and-kill, clear/kill, or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r   <= 1'b0;
            noflush_r <= 1'b0;
            ctrl_r    <= {CTRL_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            keep_r    <= {KEEP_W{1'b0}};
        end else if (load && !kill) begin
            valid_r   <= 1'b1;
            noflush_r <= load_noflush;
            ctrl_r    <= load_ctrl;
            data_r    <= load_data;
            keep_r    <= load_keep;
        end else if (load) begin
            // Beat killed as it lands: only its keep value is retained.
            valid_r   <= 1'b0;
            noflush_r <= 1'b0;
            ctrl_r    <= {CTRL_W{1'b0}};
            data_r    <= ZERO_DATA ? {DATA_W{1'b0}} : load_data;
            keep_r    <= load_keep;
        end else if (clear || kill) begin
            valid_r   <= 1'b0;
            noflush_r <= 1'b0;
            ctrl_r    <= {CTRL_W{1'b0}};
            data_r    <= ZERO_DATA ? {DATA_W{1'b0}} : data_r;
        end
    end

    assign valid   = valid_r;
    assign noflush = noflush_r;
    assign ctrl    = ctrl_r;
    assign data    = data_r;
    assign keep    = keep_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Flow-controlled pipeline stage register with optional two-entry skid
// buffer, flush with per-beat immunity, and a saturating kill counter.
// Ports:
//   clk, reset_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready               : upstream handshake
//   in_ctrl/in_data/in_keep         : incoming beat fields
//   in_noflush                      : incoming beat survives flush
//   flush                           : kill non-immune beats at this edge
//   out_valid/out_ready             : downstream handshake
//   out_ctrl/out_data/out_keep      : head (main slot) fields
//   occupancy                       : stored entries (0..2)
//   kill_cnt                        : saturating count of killed beats
// An edge is resolved in two steps: the accept/emit update yields an ordered
// list of up to two candidates (c0 = head position, c1 = skid position); the
// flush then drops non-immune candidates and the survivors compact to main.
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 96,
    parameter int KEEP_W    = 32,
    parameter bit SKID      = 1'b1,
    parameter bit ZERO_DATA = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [KEEP_W-1:0]     in_keep,
    input  logic                  in_noflush,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [KEEP_W-1:0]     out_keep,
    output logic [1:0]            occupancy,
    output logic [KILL_CNT_W-1:0] kill_cnt
);

    occ_state_e              state_r;
    occ_state_e              state_next_s;
    logic                    in_ready_r;
    logic [KILL_CNT_W-1:0]   kill_cnt_r;

    logic                    accept_s;
    logic                    emit_s;
    src_sel_e                c0_src_s;
    src_sel_e                c1_src_s;
    logic                    c0_nf_s;
    logic                    c1_nf_s;
    logic                    kill0_s;
    logic                    kill1_s;
    logic                    survive0_s;
    logic                    survive1_s;
    logic [1:0]              kills_s;
    logic [1:0]              survivors_s;

    logic                    main_load_s;
    logic                    main_kill_s;
    logic                    main_clear_s;
    logic                    main_from_skid_s;
    logic                    main_ld_nf_s;
    logic [CTRL_W-1:0]       main_ld_ctrl_s;
    logic [DATA_W-1:0]       main_ld_data_s;
    logic [KEEP_W-1:0]       main_ld_keep_s;
    logic                    skid_load_s;
    logic                    skid_clear_s;

    logic                    main_valid_s;
    logic                    main_nf_s;
    logic [CTRL_W-1:0]       main_ctrl_s;
    logic [DATA_W-1:0]       main_data_s;
    logic [KEEP_W-1:0]       main_keep_s;
    logic                    skid_valid_s;
    logic                    skid_nf_s;
    logic [CTRL_W-1:0]       skid_ctrl_s;
    logic [DATA_W-1:0]       skid_data_s;
    logic [KEEP_W-1:0]       skid_keep_s;

    // Noflush flag of whichever entry a candidate position comes from.
    function automatic logic src_noflush(
        input src_sel_e src,
        input logic     nf_in,
        input logic     nf_main,
        input logic     nf_skid
    );
        case (src)
            SRC_IN:   return nf_in;
            SRC_MAIN: return nf_main;
            SRC_SKID: return nf_skid;
            default:  return 1'b0;
        endcase
    endfunction

    // Without a skid slot in_ready must see out_ready in the same cycle.
    assign in_ready = SKID ? in_ready_r : (!main_valid_s || out_ready);
    assign accept_s = in_valid && in_ready;
    assign emit_s   = main_valid_s && out_ready;

    // Candidate order after the accept/emit update, before flush.
    always_comb begin
        c0_src_s = SRC_NONE;
        c1_src_s = SRC_NONE;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    c0_src_s = SRC_IN;
                end else begin
                    c0_src_s = SRC_NONE;
                end
            end
            ONE: begin
                if (accept_s && emit_s) begin
                    c0_src_s = SRC_IN;
                end else if (accept_s) begin
                    c0_src_s = SRC_MAIN;
                    c1_src_s = SRC_IN;
                end else if (emit_s) begin
                    c0_src_s = SRC_NONE;
                end else begin
                    c0_src_s = SRC_MAIN;
                end
            end
            TWO: begin
                if (emit_s) begin
                    c0_src_s = SRC_SKID;
                end else begin
                    c0_src_s = SRC_MAIN;
                    c1_src_s = SRC_SKID;
                end
            end
            default: begin
                c0_src_s = SRC_NONE;
                c1_src_s = SRC_NONE;
            end
        endcase
    end

    // Flush resolution: which candidates die and how many survive.
    always_comb begin
        c0_nf_s     = src_noflush(c0_src_s, in_noflush, main_nf_s, skid_nf_s);
        c1_nf_s     = src_noflush(c1_src_s, in_noflush, main_nf_s, skid_nf_s);
        kill0_s     = (c0_src_s != SRC_NONE) && flush && !c0_nf_s;
        kill1_s     = (c1_src_s != SRC_NONE) && flush && !c1_nf_s;
        survive0_s  = (c0_src_s != SRC_NONE) && !kill0_s;
        survive1_s  = (c1_src_s != SRC_NONE) && !kill1_s;
        kills_s     = {1'b0, kill0_s} + {1'b0, kill1_s};
        survivors_s = {1'b0, survive0_s} + {1'b0, survive1_s};
    end

    // Slot commands: first survivor goes to main, second to skid.
    always_comb begin
        main_load_s      = 1'b0;
        main_kill_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (survive0_s) begin
            if (c0_src_s != SRC_MAIN) begin
                main_load_s      = 1'b1;
                main_from_skid_s = (c0_src_s == SRC_SKID);
            end else begin
                main_load_s      = 1'b0;
            end
        end else if (survive1_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = (c1_src_s == SRC_SKID);
        end else if (kill0_s) begin
            // Nothing survives: the killed head still leaves its keep behind.
            main_kill_s = 1'b1;
            if (c0_src_s != SRC_MAIN) begin
                main_load_s      = 1'b1;
                main_from_skid_s = (c0_src_s == SRC_SKID);
            end else begin
                main_load_s      = 1'b0;
            end
        end else if (main_valid_s) begin
            main_clear_s = 1'b1;
        end else begin
            main_clear_s = 1'b0;
        end

        if (survive0_s && survive1_s) begin
            skid_load_s = (c1_src_s == SRC_IN);
        end else if (skid_valid_s) begin
            skid_clear_s = 1'b1;
        end else begin
            skid_clear_s = 1'b0;
        end
    end

    // Main slot load mux: the only sources are the input and the skid slot.
    always_comb begin
        if (main_from_skid_s) begin
            main_ld_nf_s   = skid_nf_s;
            main_ld_ctrl_s = skid_ctrl_s;
            main_ld_data_s = skid_data_s;
            main_ld_keep_s = skid_keep_s;
        end else begin
            main_ld_nf_s   = in_noflush;
            main_ld_ctrl_s = in_ctrl;
            main_ld_data_s = in_data;
            main_ld_keep_s = in_keep;
        end
    end

    // Next occupancy state is the number of surviving entries.
    always_comb begin
        case (survivors_s)
            2'd0:    state_next_s = EMPTY;
            2'd1:    state_next_s = ONE;
            default: state_next_s = TWO;
        endcase
    end

    // Occupancy state register and registered in_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s != TWO);
        end
    end

    // Saturating kill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kill_cnt_r <= {KILL_CNT_W{1'b0}};
        end else begin
            kill_cnt_r <= kill_cnt_add(kill_cnt_r, kills_s);
        end
    end

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .KEEP_W    (KEEP_W),
        .ZERO_DATA (ZERO_DATA)
    ) u_main (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (main_load_s),
        .kill         (main_kill_s),
        .clear        (main_clear_s),
        .load_noflush (main_ld_nf_s),
        .load_ctrl    (main_ld_ctrl_s),
        .load_data    (main_ld_data_s),
        .load_keep    (main_ld_keep_s),
        .valid        (main_valid_s),
        .noflush      (main_nf_s),
        .ctrl         (main_ctrl_s),
        .data         (main_data_s),
        .keep         (main_keep_s)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .KEEP_W    (KEEP_W),
                .ZERO_DATA (ZERO_DATA)
            ) u_skid (
                .clk          (clk),
                .reset_n      (reset_n),
                .load         (skid_load_s),
                .kill         (1'b0),
                .clear        (skid_clear_s),
                .load_noflush (in_noflush),
                .load_ctrl    (in_ctrl),
                .load_data    (in_data),
                .load_keep    (in_keep),
                .valid        (skid_valid_s),
                .noflush      (skid_nf_s),
                .ctrl         (skid_ctrl_s),
                .data         (skid_data_s),
                .keep         (skid_keep_s)
            );
        end else begin : g_no_skid
            assign skid_valid_s = 1'b0;
            assign skid_nf_s    = 1'b0;
            assign skid_ctrl_s  = {CTRL_W{1'b0}};
            assign skid_data_s  = {DATA_W{1'b0}};
            assign skid_keep_s  = {KEEP_W{1'b0}};
        end
    endgenerate

    assign out_valid = main_valid_s;
    assign out_ctrl  = main_ctrl_s;
    assign out_data  = main_data_s;
    assign out_keep  = main_keep_s;
    assign occupancy = state_r;
    assign kill_cnt  = kill_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one SKID=1 instance (A) and one SKID=0 instance (B) from shared
// inputs and compares both against a queue-based model of the stage.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef struct {
        logic        nf;
        logic [15:0] ctrl;
        logic [95:0] data;
        logic [31:0] keep;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;
    logic [31:0] in_keep;
    logic        in_noflush;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [15:0] a_out_ctrl, b_out_ctrl, a_kill_cnt, b_kill_cnt;
    logic [95:0] a_out_data, b_out_data;
    logic [31:0] a_out_keep, b_out_keep;
    logic [1:0]  a_occupancy, b_occupancy;

    int n_checks = 0;
    int n_errors = 0;

    beat_t       mq0[$];
    beat_t       mq1[$];
    logic [31:0] lkeep [2];
    int          kills [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(96), .KEEP_W(32), .SKID(1'b1), .ZERO_DATA(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_keep(in_keep), .in_noflush(in_noflush),
        .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .out_keep(a_out_keep), .occupancy(a_occupancy), .kill_cnt(a_kill_cnt)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(96), .KEEP_W(32), .SKID(1'b0), .ZERO_DATA(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_keep(in_keep), .in_noflush(in_noflush),
        .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .out_keep(b_out_keep), .occupancy(b_occupancy), .kill_cnt(b_kill_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        lkeep[0] = 32'h0;
        lkeep[1] = 32'h0;
        kills[0] = 0;
        kills[1] = 0;
    endtask

    // One clock edge of the stage: pop on emit, push on accept, then drop
    // every non-immune entry if flushing.
    task automatic model_step(input int which, input bit iv, input beat_t b, input bit fl, input bit ordy);
        beat_t q[$];
        beat_t s[$];
        bit    rdy, acc, emit;
        int    killed;
        if (which == 0) q = mq0; else q = mq1;
        if (which == 0) rdy = (q.size() < 2);
        else            rdy = (q.size() == 0) || ordy;
        emit = (q.size() > 0) && ordy;
        acc  = iv && rdy;
        if (emit) void'(q.pop_front());
        if (acc) q.push_back(b);
        killed = 0;
        foreach (q[j]) begin
            if (fl && !q[j].nf) killed++;
            else s.push_back(q[j]);
        end
        kills[which] = kills[which] + killed;
        if (kills[which] > 65535) kills[which] = 65535;
        if (s.size() > 0)      lkeep[which] = s[0].keep;
        else if (q.size() > 0) lkeep[which] = q[0].keep;
        if (which == 0) mq0 = s; else mq1 = s;
    endtask

    task automatic check_dut(input int which);
        beat_t       q[$];
        string       p;
        logic        ov, ir, exp_ir;
        logic [15:0] oc, kc, exp_c;
        logic [95:0] od, exp_d;
        logic [31:0] ok, exp_k;
        logic [1:0]  occ;
        if (which == 0) begin
            q = mq0; p = "A";
            ov = a_out_valid; ir = a_in_ready; oc = a_out_ctrl; kc = a_kill_cnt;
            od = a_out_data; ok = a_out_keep; occ = a_occupancy;
            exp_ir = (q.size() < 2);
        end else begin
            q = mq1; p = "B";
            ov = b_out_valid; ir = b_in_ready; oc = b_out_ctrl; kc = b_kill_cnt;
            od = b_out_data; ok = b_out_keep; occ = b_occupancy;
            exp_ir = (q.size() == 0) || out_ready;
        end
        if (q.size() > 0) begin
            exp_c = q[0].ctrl; exp_d = q[0].data; exp_k = q[0].keep;
        end else begin
            exp_c = 16'h0; exp_d = 96'h0; exp_k = lkeep[which];
        end
        check_eq({p, ".out_valid"}, ov, q.size() > 0);
        check_eq({p, ".out_ctrl"}, oc, exp_c);
        check_eq({p, ".out_data"}, od, exp_d);
        check_eq({p, ".out_keep"}, ok, exp_k);
        check_eq({p, ".occupancy"}, occ, q.size());
        check_eq({p, ".kill_cnt"}, kc, kills[which]);
        check_eq({p, ".in_ready"}, ir, exp_ir);
    endtask

    // Drive one cycle's inputs after the falling edge, check both DUTs,
    // then advance the model for the coming rising edge.
    task automatic step_cycle(input bit iv, input logic [15:0] c, input logic [95:0] d,
                              input logic [31:0] k, input bit nf, input bit fl, input bit ordy);
        beat_t b;
        @(negedge clk);
        in_valid = iv; in_ctrl = c; in_data = d; in_keep = k;
        in_noflush = nf; flush = fl; out_ready = ordy;
        #1;
        check_dut(0);
        check_dut(1);
        b.nf = nf; b.ctrl = c; b.data = d; b.keep = k;
        model_step(0, iv, b, fl, ordy);
        model_step(1, iv, b, fl, ordy);
    endtask

    task automatic drain();
        repeat (3) step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_ctrl = 16'h0; in_data = 96'h0;
        in_keep = 32'h0; in_noflush = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming: one beat per cycle, head follows one cycle behind.
        for (int i = 0; i < 8; i++) begin
            step_cycle(1'b1, 16'(i + 1), {3{32'($urandom)}}, 32'($urandom), 1'b0, 1'b0, 1'b1);
            if (i > 0) begin
                check_eq("stream.ctrl", a_out_ctrl, i);
                check_eq("stream.occ", a_occupancy, 2'd1);
            end
        end
        drain();

        // Backpressure: two beats park, then drain in order.
        step_cycle(1'b1, 16'hA1, 96'h111, 32'h1A, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 16'hB2, 96'h222, 32'h2B, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("bp.occ", a_occupancy, 2'd2);
        check_eq("bp.in_ready", a_in_ready, 1'b0);
        check_eq("bp.hold_a", a_out_ctrl, 16'hA1);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("bp.first_a", a_out_ctrl, 16'hA1);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("bp.then_b", a_out_ctrl, 16'hB2);
        drain();

        // Flush with mixed load: A dies, immune B moves to main.
        step_cycle(1'b1, 16'hA1, 96'h333, 32'hAA, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 16'hB2, 96'h444, 32'hBB, 1'b1, 1'b0, 1'b0);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("mix.ctrl", a_out_ctrl, 16'hB2);
        check_eq("mix.keep", a_out_keep, 32'hBB);
        check_eq("mix.kill_cnt", a_kill_cnt, 16'd1);
        drain();

        // Flush with same-cycle accept: killed, then immune.
        step_cycle(1'b1, 16'h5, 96'h555, 32'h40, 1'b0, 1'b1, 1'b1);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("fa.valid", a_out_valid, 1'b0);
        check_eq("fa.ctrl", a_out_ctrl, 16'h0);
        check_eq("fa.keep", a_out_keep, 32'h40);
        check_eq("fa.kill_cnt", a_kill_cnt, 16'd2);
        step_cycle(1'b1, 16'h6, 96'h666, 32'h44, 1'b1, 1'b1, 1'b0);
        step_cycle(1'b0, 16'h0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("fa_nf.valid", a_out_valid, 1'b1);
        check_eq("fa_nf.ctrl", a_out_ctrl, 16'h6);
        check_eq("fa_nf.data", a_out_data, 96'h666);
        check_eq("fa_nf.keep", a_out_keep, 32'h44);
        drain();

        // SKID=0 with out_ready toggling every cycle.
        for (int i = 0; i < 12; i++) begin
            step_cycle(1'b1, 16'(i + 32), {3{32'($urandom)}}, 32'($urandom), 1'b1, 1'b0, 1'(i % 2));
            check_eq("b.occ_max", b_occupancy <= 2'd1, 1'b1);
        end
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step_cycle(($urandom_range(3, 0) != 0), 16'($urandom), {$urandom, $urandom, $urandom},
                       32'($urandom), 1'($urandom_range(1, 0)), ($urandom_range(5, 0) == 0),
                       ($urandom_range(2, 0) != 0));
        end
        drain();

        // Asynchronous reset with two stored entries.
        step_cycle(1'b1, 16'hC1, 96'h777, 32'hC1, 1'b0, 1'b0, 1'b0);
        step_cycle(1'b1, 16'hC2, 96'h888, 32'hC2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rst.occ_before", a_occupancy, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst.valid", a_out_valid, 1'b0);
        check_eq("rst.ctrl", a_out_ctrl, 16'h0);
        check_eq("rst.data", a_out_data, 96'h0);
        check_eq("rst.keep", a_out_keep, 32'h0);
        check_eq("rst.kill_cnt", a_kill_cnt, 16'h0);
        check_eq("rst.occ", a_occupancy, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rst.in_ready", a_in_ready, 1'b1);
        check_dut(0);
        check_dut(1);
        step_cycle(1'b1, 16'hD1, 96'h999, 32'hD1, 1'b0, 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that generalises the fixed ID/EX register into one block usable between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field, a datapath field and a flush-immune "keep" field (e.g. PC+4) under a valid/ready handshake. An optional two-entry skid buffer lets the block register in_ready. A synchronous flush kills in-flight beats unless they are marked flush-immune, and killed beats are counted for performance monitoring.

## Interface
Parameters:
- CTRL_W, 16: control-field width; always zero while out_valid=0.
- DATA_W, 96: datapath-field width (operands, immediate, register indices).
- KEEP_W, 32: flush-immune field width; captured on every accepted beat and never zeroed.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- ZERO_DATA, 1: 1 forces out_data to zero while out_valid=0.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: block can accept a beat.
- in_ctrl, in, CTRL_W: control field.
- in_data, in, DATA_W: datapath field.
- in_keep, in, KEEP_W: flush-immune field.
- in_noflush, in, 1: beat survives flush (link/JAL-type).
- flush, in, 1: kill non-immune beats at this edge.
- out_valid, out, 1: downstream beat present.
- out_ready, in, 1: downstream accepts.
- out_ctrl, out, CTRL_W; out_data, out, DATA_W; out_keep, out, KEEP_W: head-entry fields.
- occupancy, out, 2: stored entries (0..2; max 1 when SKID=0).
- kill_cnt, out, 16: saturating count of beats killed by flush.

## Operation
- Accept means in_valid & in_ready at an edge. Emit means out_valid & out_ready at an edge.
- Storage consists of a main slot (the head, driving out_*) and, when SKID=1, a skid slot. Each slot holds {valid, noflush, ctrl, data, keep}.
- State machine: EMPTY, ONE, TWO. The state is encoded by occupancy.
  - EMPTY: accept goes to ONE.
  - ONE: accept with no emit goes to TWO. Accept with emit stays in ONE. Emit with no accept goes to EMPTY.
  - TWO: emit goes to ONE, and the skid slot moves to main. There is no accept in TWO.
- in_ready:
  - SKID=1: registered, equal to (next occupancy < 2).
  - SKID=0: in_ready = !out_valid | out_ready, and TWO is unreachable.
- Flush is applied at the edge after the normal accept/emit update:
  - Every stored slot with noflush=0 is killed, along with the accepted beat if its in_noflush=0.
  - A killed slot gets valid=0 and ctrl=0. It also gets data=0 when ZERO_DATA=1. Its keep value is retained.
  - Surviving entries compact toward main, preserving order.
  - A beat emitted at the flush edge is already consumed and is not killed.
- kill_cnt increments by the number of beats killed at that edge (0..2 with SKID=1; 0..1 with SKID=0), saturating at 16'hFFFF.
- While out_valid=0, out_ctrl=0 and out_keep holds its last captured value.

## Timing
- Latency: an accept at edge N gives out_valid at N+1 when the stage was empty.
- Throughput: one beat per cycle with out_ready held high.
- Reset (reset_n low, asynchronous): all slots invalid and zeroed, out_valid=0, out_ctrl/out_data/out_keep=0, occupancy=0, kill_cnt=0, in_ready=1 (it reflects an empty stage).
- Reset asserted mid-transfer discards all entries; no partial beat survives.
- Flush and accept in the same cycle: the incoming beat is accepted, then killed unless in_noflush=1.
- out_* never change while out_valid & !out_ready, except when a flush kills the head.

## Structure
- Package pipe_pkg holds the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the KILL_CNT_W=16 constant.
- Sub-module pipe_slot is one storage entry with load, clear and kill logic. It is instantiated once for main, plus once more for skid when SKID=1.

## Test plan
- Streaming: SKID=1, out_ready=1, 8 beats with ctrl=1..8 → out_ctrl=1..8 on consecutive cycles starting one cycle after the first accept; occupancy stays 1.
- Backpressure: out_ready=0 and two beats A and B → occupancy=2 and in_ready=0 on the next cycle; out_ctrl holds A. Release out_ready → A, then B, with no loss.
- Flush with a mixed load: stored A (noflush=0) and B (noflush=1), then flush → B moves to main, kill_cnt=1, A's keep is not visible.
- Flush with same-cycle accept: in_noflush=0, in_keep=32'h40 → out_valid=0, out_ctrl=0, out_keep=32'h40, kill_cnt +1. Repeat with in_noflush=1 → the beat is delivered intact.
- SKID=0: out_ready toggles each cycle → in_ready mirrors !out_valid | out_ready combinationally; occupancy never exceeds 1.
- Asynchronous reset mid-stream with occupancy=2 → on the reset_n fall, out_valid=0, all outputs 0, kill_cnt=0; in_ready=1 once reset_n is released.
